// File: rtl/iic_target_regs.sv
// I2C target with an 8-bit register pointer driving an external register-file port.
// Define IIC_TARGET_READ_EN to build the read path (RDATA/RDATA_ACK states, Reg_rd strobe).
`timescale 1ns/1ps
module iic_target_regs #(
   parameter logic [6:0] TARGET_ADDR = 7'h4C,
   parameter int         HOLD_CYCLES = 4
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       SCL_in,
   input  logic       SDA_in,
   output logic       SDA_oe,
   output logic [7:0] Reg_addr,
   output logic [7:0] Reg_wdata,
   output logic       Reg_wr,
   output logic       Reg_rd,
   input  logic [7:0] Reg_rdata,
   output logic       Busy,
   output logic [3:0] Dbg_state
);

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_ADDR      = 4'd1,
      ST_ADDR_ACK  = 4'd2,
      ST_PTR       = 4'd3,
      ST_PTR_ACK   = 4'd4,
      ST_WDATA     = 4'd5,
      ST_WDATA_ACK = 4'd6,
      ST_RDATA     = 4'd7,
      ST_RDATA_ACK = 4'd8,
      ST_IGNORE    = 4'd9
   } state_t;

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   state_t            state;
   logic [2:0]        scl_sync;
   logic [2:0]        sda_sync;
   logic [7:0]        shift;
   logic [3:0]        bit_cnt;
   logic [HOLD_W-1:0] hold_cnt;
   logic              drive_val;
   logic              scl;
   logic              scl_d;
   logic              sda;
   logic              sda_d;
   logic              scl_rise;
   logic              scl_fall;
   logic              start_det;
   logic              stop_det;

   assign Dbg_state = state;

   // Bus idles high, so synchronisers reset to 1 to avoid a false edge on release.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         scl_sync <= 3'b111;
         sda_sync <= 3'b111;
      end else begin
         scl_sync <= {scl_sync[1:0], SCL_in};
         sda_sync <= {sda_sync[1:0], SDA_in};
      end
   end

   assign scl       = scl_sync[1];
   assign scl_d     = scl_sync[2];
   assign sda       = sda_sync[1];
   assign sda_d     = sda_sync[2];
   assign scl_rise  = scl & ~scl_d;
   assign scl_fall  = ~scl & scl_d;
   assign start_det = scl & scl_d & sda_d & ~sda;
   assign stop_det  = scl & scl_d & ~sda_d & sda;

   // Level SDA should settle to once the hold time after an SCL fall has elapsed.
   always_comb begin
      drive_val = 1'b0;
      case (state)
         ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: drive_val = 1'b1;
`ifdef IIC_TARGET_READ_EN
         ST_RDATA:                              drive_val = ~shift[7];
`endif
         default:                               drive_val = 1'b0;
      endcase
   end

`ifdef IIC_TARGET_READ_EN
   logic rd_q;
   logic rw;
   logic ack_nack;
   assign Reg_rd = rd_q;
`else
   logic unused_rdata;
   assign Reg_rd       = 1'b0;
   assign unused_rdata = ^Reg_rdata;
`endif

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= ST_IDLE;
         SDA_oe    <= 1'b0;
         Reg_addr  <= 8'h00;
         Reg_wdata <= 8'h00;
         Reg_wr    <= 1'b0;
         Busy      <= 1'b0;
         shift     <= 8'h00;
         bit_cnt   <= 4'd0;
         hold_cnt  <= '0;
`ifdef IIC_TARGET_READ_EN
         rd_q      <= 1'b0;
         rw        <= 1'b0;
         ack_nack  <= 1'b1;
`endif
      end else begin
         Reg_wr <= 1'b0;
`ifdef IIC_TARGET_READ_EN
         rd_q <= 1'b0;
         if (rd_q)
            shift <= Reg_rdata;
`endif
         // The pointer advances in the cycle after each strobe, so a read strobe prefetches the next byte.
         if (Reg_wr || Reg_rd)
            Reg_addr <= Reg_addr + 8'd1;

         if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HOLD_W'(1))
               SDA_oe <= drive_val;
         end

         if (stop_det) begin
            state    <= ST_IDLE;
            Busy     <= 1'b0;
            SDA_oe   <= 1'b0;
            hold_cnt <= '0;
            bit_cnt  <= 4'd0;
         end else if (start_det) begin
            state    <= ST_ADDR;
            Busy     <= 1'b1;
            SDA_oe   <= 1'b0;
            hold_cnt <= '0;
            bit_cnt  <= 4'd0;
         end else if (scl_rise) begin
            case (state)
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  shift   <= {shift[6:0], sda};
                  bit_cnt <= bit_cnt + 4'd1;
               end
`ifdef IIC_TARGET_READ_EN
               ST_RDATA:     bit_cnt  <= bit_cnt + 4'd1;
               ST_RDATA_ACK: ack_nack <= sda;
`endif
               default: ;
            endcase
         end else if (scl_fall) begin
            hold_cnt <= HOLD_W'(HOLD_CYCLES);
            case (state)
               ST_ADDR: begin
                  if (bit_cnt == 4'd8) begin
                     bit_cnt <= 4'd0;
                     if (shift[7:1] == TARGET_ADDR) begin
`ifdef IIC_TARGET_READ_EN
                        rw    <= shift[0];
                        state <= ST_ADDR_ACK;
`else
                        state <= shift[0] ? ST_IGNORE : ST_ADDR_ACK;
`endif
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end
               end
               ST_ADDR_ACK: begin
                  bit_cnt <= 4'd0;
`ifdef IIC_TARGET_READ_EN
                  if (rw) begin
                     state <= ST_RDATA;
                     rd_q  <= 1'b1;
                  end else begin
                     state <= ST_PTR;
                  end
`else
                  state <= ST_PTR;
`endif
               end
               ST_PTR: begin
                  if (bit_cnt == 4'd8) begin
                     bit_cnt  <= 4'd0;
                     Reg_addr <= shift;
                     state    <= ST_PTR_ACK;
                  end
               end
               ST_PTR_ACK: begin
                  bit_cnt <= 4'd0;
                  state   <= ST_WDATA;
               end
               ST_WDATA: begin
                  if (bit_cnt == 4'd8) begin
                     bit_cnt   <= 4'd0;
                     Reg_wdata <= shift;
                     Reg_wr    <= 1'b1;
                     state     <= ST_WDATA_ACK;
                  end
               end
               ST_WDATA_ACK: begin
                  bit_cnt <= 4'd0;
                  state   <= ST_WDATA;
               end
`ifdef IIC_TARGET_READ_EN
               ST_RDATA: begin
                  if (bit_cnt == 4'd8) begin
                     bit_cnt <= 4'd0;
                     state   <= ST_RDATA_ACK;
                  end else begin
                     shift <= {shift[6:0], 1'b0};
                  end
               end
               ST_RDATA_ACK: begin
                  bit_cnt <= 4'd0;
                  if (!ack_nack) begin
                     state <= ST_RDATA;
                     rd_q  <= 1'b1;
                  end else begin
                     state <= ST_IGNORE;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_iic_target_regs.sv
// Directed bench for iic_target_regs: bit-banged I2C initiator with an open-drain SDA model.
`timescale 1ns/1ps
module tb_iic_target_regs;

  localparam int QTR = 5;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_wr;
  logic       reg_rd;
  logic [7:0] reg_rdata;
  logic       busy;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  int          oe_cnt = 0;

  assign sda_bus   = m_sda & ~sda_oe;
  assign reg_rdata = reg_addr ^ 8'h5A;

  iic_target_regs dut (
    .Clk       (clk),
    .Reset_n   (reset_n),
    .SCL_in    (m_scl),
    .SDA_in    (sda_bus),
    .SDA_oe    (sda_oe),
    .Reg_addr  (reg_addr),
    .Reg_wdata (reg_wdata),
    .Reg_wr    (reg_wr),
    .Reg_rd    (reg_rd),
    .Reg_rdata (reg_rdata),
    .Busy      (busy),
    .Dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // bus monitor
  always @(negedge clk) begin
    if (reg_wr) wr_q.push_back({reg_addr, reg_wdata});
    if (reg_rd) rd_q.push_back(reg_addr);
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wait_q();
    repeat (QTR) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    wait_q(); m_sda = 1'b1;
    wait_q(); m_scl = 1'b1;
    wait_q(); m_sda = 1'b0;
    wait_q(); m_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_q(); m_sda = 1'b0;
    wait_q(); m_scl = 1'b1;
    wait_q(); m_sda = 1'b1;
    wait_q();
    wait_q();
  endtask

  task automatic i2c_bit(input logic v, output logic s);
    wait_q(); m_sda = v;
    wait_q(); m_scl = 1'b1;
    wait_q(); s = sda_bus;
    wait_q(); m_scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) i2c_bit(b[i], s);
    i2c_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      i2c_bit(1'b1, s);
      d[i] = s;
    end
    i2c_bit(~ack, s);
  endtask

  // scoreboard: compare new writes since wi against exp_q
  task automatic check_writes(input string tag, input int wi);
    chk({tag, "_wr_count"}, 16'(wr_q.size() - wi), 16'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (wi + k < wr_q.size()) chk({tag, "_wr"}, wr_q[wi + k], exp_q[k]);
    end
    exp_q.delete();
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    logic [7:0] addr_byte;
    int         wi;
    int         ri;
    int         ob;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_oe",    16'(sda_oe),    16'h0);
    chk("rst_reg_addr",  16'(reg_addr),  16'h0);
    chk("rst_reg_wdata", 16'(reg_wdata), 16'h0);
    chk("rst_reg_wr",    16'(reg_wr),    16'h0);
    chk("rst_reg_rd",    16'(reg_rd),    16'h0);
    chk("rst_busy",      16'(busy),      16'h0);
    chk("rst_state",     16'(dbg_state), 16'h0);
    reset_n = 1'b1;
    wait_q();

    // single write 0x98,0x05,0xA4
    wi = wr_q.size();
    i2c_start();
    chk("t1_busy_on", 16'(busy), 16'h1);
    send_byte(8'h98, ack); chk("t1_ack_addr", 16'(ack), 16'h1);
    send_byte(8'h05, ack); chk("t1_ack_ptr",  16'(ack), 16'h1);
    send_byte(8'hA4, ack); chk("t1_ack_data", 16'(ack), 16'h1);
    i2c_stop();
    chk("t1_busy_off", 16'(busy), 16'h0);
    exp_q.push_back(16'h05A4);
    check_writes("t1", wi);
    chk("t1_addr", 16'(reg_addr), 16'h06);

    // pointer wrap 0xFF -> 0x00
    wi = wr_q.size();
    i2c_start();
    send_byte(8'h98, ack); chk("t2_ack_addr", 16'(ack), 16'h1);
    send_byte(8'hFF, ack); chk("t2_ack_ptr",  16'(ack), 16'h1);
    send_byte(8'h11, ack); chk("t2_ack_d0",   16'(ack), 16'h1);
    send_byte(8'h22, ack); chk("t2_ack_d1",   16'(ack), 16'h1);
    i2c_stop();
    exp_q.push_back(16'hFF11);
    exp_q.push_back(16'h0022);
    check_writes("t2", wi);
    chk("t2_addr", 16'(reg_addr), 16'h01);

    // foreign address 0xEC is ignored
    wi = wr_q.size();
    ob = oe_cnt;
    i2c_start();
    send_byte(8'hEC, ack); chk("t3_nack_addr", 16'(ack), 16'h0);
    chk("t3_state_ignore", 16'(dbg_state), 16'h9);
    send_byte(8'h01, ack); chk("t3_nack_data", 16'(ack), 16'h0);
    chk("t3_busy_mid", 16'(busy), 16'h1);
    i2c_stop();
    chk("t3_busy_off", 16'(busy), 16'h0);
    chk("t3_oe_never", 16'(oe_cnt - ob), 16'h0);
    check_writes("t3", wi);
    chk("t3_addr", 16'(reg_addr), 16'h01);

`ifdef IIC_TARGET_READ_EN
    // pointer set then repeated-start read of two bytes
    ri = rd_q.size();
    i2c_start();
    send_byte(8'h98, ack); chk("t4_ack_waddr", 16'(ack), 16'h1);
    send_byte(8'h10, ack); chk("t4_ack_ptr",   16'(ack), 16'h1);
    i2c_start();
    send_byte(8'h99, ack); chk("t4_ack_raddr", 16'(ack), 16'h1);
    read_byte(1'b1, d);    chk("t4_rd_byte0",  16'(d), 16'h4A);
    read_byte(1'b0, d);    chk("t4_rd_byte1",  16'(d), 16'h4B);
    chk("t4_state_ignore", 16'(dbg_state), 16'h9);
    i2c_stop();
    chk("t4_rd_count", 16'(rd_q.size() - ri), 16'h2);
    if (rd_q.size() - ri == 2) begin
      chk("t4_rd_addr0", 16'(rd_q[ri]),     16'h10);
      chk("t4_rd_addr1", 16'(rd_q[ri + 1]), 16'h11);
    end
    chk("t4_addr", 16'(reg_addr), 16'h12);
    chk("t4_busy_off", 16'(busy), 16'h0);
`else
    // read request without a read path is NACKed and ignored
    ri = rd_q.size();
    ob = oe_cnt;
    i2c_start();
    send_byte(8'h99, ack); chk("t6_nack_raddr", 16'(ack), 16'h0);
    chk("t6_state_ignore", 16'(dbg_state), 16'h9);
    read_byte(1'b0, d);
    chk("t6_still_ignore", 16'(dbg_state), 16'h9);
    i2c_stop();
    chk("t6_state_idle", 16'(dbg_state), 16'h0);
    chk("t6_no_rd", 16'(rd_q.size() - ri), 16'h0);
    chk("t6_oe_never", 16'(oe_cnt - ob), 16'h0);
    chk("t6_addr", 16'(reg_addr), 16'h01);
`endif

    // async reset while the target holds the address ACK
    i2c_start();
    addr_byte = 8'h98;
    for (int i = 7; i >= 0; i--) i2c_bit(addr_byte[i], s);
    wait_q(); m_sda = 1'b1;
    wait_q(); m_scl = 1'b1;
    wait_q();
    chk("t5_oe_before_rst", 16'(sda_oe), 16'h1);
    reset_n = 1'b0;
    #1;
    chk("t5_oe_async",   16'(sda_oe),   16'h0);
    chk("t5_busy_async", 16'(busy),     16'h0);
    chk("t5_addr_async", 16'(reg_addr), 16'h00);
    wait_q();
    reset_n = 1'b1;
    wait_q(); m_scl = 1'b0;
    i2c_stop();
    wi = wr_q.size();
    i2c_start();
    send_byte(8'h98, ack); chk("t5_ack_addr", 16'(ack), 16'h1);
    send_byte(8'h20, ack); chk("t5_ack_ptr",  16'(ack), 16'h1);
    send_byte(8'h33, ack); chk("t5_ack_data", 16'(ack), 16'h1);
    i2c_stop();
    exp_q.push_back(16'h2033);
    check_writes("t5", wi);
    chk("t5_addr", 16'(reg_addr), 16'h21);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
